// File: rtl/uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_pkg
// Purpose  : Definitions shared by the p03 UART transmitter and receiver.
//            It holds the default frame geometry and the receiver state
//            encoding.
// Contents : UART_N            - default data bits per frame
//            UART_CLKS_PER_BIT - default clock cycles per bit period
//            uart_rx_state_t   - receiver FSM states
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_N            = 8;
  localparam int UART_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } uart_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_sync
// Purpose  : Two-flop synchronizer for a single asynchronous bit. Both flops
//            load RST_VAL on reset, so an idle-high line reads as idle
//            straight out of reset.
// Ports    : clk - clock
//            rst - synchronous active-high reset
//            d   - asynchronous input
//            q   - synchronized output
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_rx
// Purpose  : Oversampling UART receiver. It validates the start bit at
//            mid-bit and samples the data bits LSB first at mid-bit. It
//            checks the stop bit and, optionally, even parity. Each good
//            frame is delivered with a one-cycle rx_valid strobe.
// Config   : define UART_RX_PARITY_EN to expect an even-parity bit between
//            the data and the stop bit. Without it, parity_err stays 0.
// Ports    : clk        - clock
//            rst        - synchronous active-high reset
//            serial_rx  - asynchronous serial line, idle high
//            rx_data    - last good received word
//            rx_valid   - one-cycle pulse, rx_data updated
//            frame_err  - one-cycle pulse, stop bit sampled low
//            parity_err - one-cycle pulse alongside rx_valid on mismatch
//            busy       - receiver is not idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int N            = UART_N,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         serial_rx,
  output logic [N-1:0] rx_data,
  output logic         rx_valid,
  output logic         frame_err,
  output logic         parity_err,
  output logic         busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(N + 1);

  localparam logic [CW-1:0] CNT_HALF  = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_BIT   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(N - 1);

  logic           s;
  uart_rx_state_t state;
  logic [CW-1:0]  cyc_cnt;
  logic [BW-1:0]  bit_cnt;
  logic [N-1:0]   shreg;
`ifdef UART_RX_PARITY_EN
  logic           par_bad;
`endif

  // The line is held idle (1) through reset so that no false start edge
  // appears when reset is released.
  uart_sync #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (serial_rx),
    .q   (s)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cyc_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
`endif
    end else begin
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;

      case (state)
        IDLE: begin
          if (!s) begin
            state   <= START;
            cyc_cnt <= '0;
          end
        end

        // Recheck the line at mid start bit. If it is high again, the low
        // level was a glitch and not a frame.
        START: begin
          if (cyc_cnt == CNT_HALF) begin
            if (s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              cyc_cnt <= '0;
              bit_cnt <= '0;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        // The counter is phased to mid-bit, so every full period lands on
        // the centre of the next bit. LSB arrives first, so shift right.
        DATA: begin
          if (cyc_cnt == CNT_BIT) begin
            cyc_cnt <= '0;
            shreg   <= {s, shreg[N-1:1]};
            if (bit_cnt == BITS_LAST) begin
              bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        // Even parity: the data bits together with the parity bit XOR to 0.
        PARITY: begin
          if (cyc_cnt == CNT_BIT) begin
            cyc_cnt <= '0;
            par_bad <= s ^ (^shreg);
            state   <= STOP;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
`endif

        // Leaving at mid-stop gives half a bit of slack before the next
        // start edge, so back-to-back frames are not missed.
        STOP: begin
          if (cyc_cnt == CNT_BIT) begin
            cyc_cnt <= '0;
            if (s) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err <= par_bad;
`endif
              state    <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        // After a bad stop bit the line may stay low (break). Wait for it
        // to return high so that the low level is not taken as a new start.
        WAIT_IDLE: begin
          if (s) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx at default parameters. The
//            stimulus pushes the expected pulse (kind, data, parity flag and
//            the clock edge of arrival) into a queue. A monitor pops and
//            compares each rx_valid/frame_err pulse. Define
//            UART_RX_PARITY_EN to exercise the parity frame format.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int N    = 8;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_EDGE = 2 + HALF + (N + 1) * CPB + CPB;
`else
  localparam int STOP_EDGE = 2 + HALF + (N + 1) * CPB;
`endif

  typedef struct {
    bit         is_ferr;
    logic [7:0] data;
    bit         perr;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       q[$];
  exp_t       e;
  logic [7:0] last_good = 8'h00;

  uart_rx #(
    .N            (N),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_rx  (serial_rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (parity_err && !rx_valid) check("parity_err_alone", 32'd1, 32'd0);
      if (rx_valid || frame_err) begin
        if (q.size() == 0) begin
          check("unexpected_pulse", {30'd0, frame_err, rx_valid}, 32'd0);
        end else begin
          e = q.pop_front();
          check("pulse_kind", {30'd0, frame_err, rx_valid}, e.is_ferr ? 32'd2 : 32'd1);
          check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
          check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
          check("pulse_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Called and returns at #1 after a rising edge.
  task automatic hold(input logic b, input int n);
    serial_rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // The edge after the call is E0.
  task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit par_flip);
    exp_t x;
    if (stop_bit) last_good = d;
    x.is_ferr = !stop_bit;
    x.data    = last_good;
`ifdef UART_RX_PARITY_EN
    x.perr    = stop_bit && par_flip;
`else
    x.perr    = 1'b0;
`endif
    x.cyc     = cyc + 1 + STOP_EDGE;
    q.push_back(x);
    hold(1'b0, CPB);
    for (int i = 0; i < N; i++) hold(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    hold((^d) ^ par_flip, CPB);
`endif
    hold(stop_bit, CPB);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
    check({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_parity_err"}, {31'd0, parity_err}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    serial_rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    hold(1'b1, 5);

    // Glitch: three low cycles. START sees the line high at mid-bit.
    hold(1'b0, 3);
    serial_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("glitch_busy_mid", {31'd0, busy}, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check("glitch_busy_end", {31'd0, busy}, 32'd0);
    hold(1'b1, CPB);

    // Bad stop bit, then the line stays low (break), then a clean frame.
    send_frame(8'hA5, 1'b0, 1'b0);
    hold(1'b0, 20);
    check("break_busy", {31'd0, busy}, 32'd1);
    hold(1'b0, 20);
    hold(1'b1, 2 * CPB);
    send_frame(8'h3C, 1'b1, 1'b0);
    hold(1'b1, CPB);

    send_frame(8'h55, 1'b1, 1'b0);
    hold(1'b1, CPB);

    // Back-to-back frames with a single stop bit.
    send_frame(8'hA5, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    hold(1'b1, CPB);

    // Reset in the middle of the data bits of 0xFF.
    hold(1'b0, CPB);
    hold(1'b1, 2 * CPB + 8);
    rst = 1'b1;
    @(posedge clk);
    #1;
    last_good = 8'h00;
    check_all_zero("midrst");
    rst = 1'b0;
    hold(1'b1, 2 * CPB);
    send_frame(8'h81, 1'b1, 1'b0);
    hold(1'b1, CPB);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    hold(1'b1, CPB);
    send_frame(8'h07, 1'b1, 1'b0);
    hold(1'b1, CPB);
`endif

    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("queue_drained", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the p03 UART datapath: the receiving end of the frames the UART transmitter puts on `serial_tx`. It oversamples an asynchronous serial line, validates the start bit, samples each data bit at mid-bit (LSB first), and checks the stop bit. Each good frame is presented as a parallel word with a one-cycle valid strobe. It sits between the pin (or a `serial_tx` loopback) and the consumer of `rx_data`.

## Interface
- `N`, 8, data bits per frame
- `CLKS_PER_BIT`, 16, clock cycles per bit period; even, ≥4; `HALF` = `CLKS_PER_BIT`/2
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `serial_rx`  in  1  asynchronous serial line, idle high
- `rx_data`  out  N  last good received word
- `rx_valid`  out  1  one-cycle pulse, `rx_data` updated this cycle
- `frame_err`  out  1  one-cycle pulse, stop bit sampled low
- `parity_err`  out  1  one-cycle pulse with `rx_valid` on parity mismatch (always 0 without the macro)
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- The line passes through a 2-flop synchronizer, reset to 1; all decisions use the synchronized bit `s`.
- Reset: state IDLE, bit counter 0, cycle counter 0, `rx_data`=0, all pulses 0, `busy`=0. Reset mid-frame aborts the frame with no output pulse.
- IDLE: `s`==0 → START, cycle counter cleared.
- START: when the cycle counter reaches `HALF`-1, sample `s`. If 1 (glitch), return to IDLE with no pulse. If 0, go to DATA and clear both counters.
- DATA: every `CLKS_PER_BIT` cycles sample `s` and shift it in from the MSB side (right shift, LSB first). After N samples go to PARITY (macro defined) or STOP.
- PARITY: after `CLKS_PER_BIT` cycles sample the parity bit and compare it to the XOR of the data.
- STOP: after `CLKS_PER_BIT` cycles sample `s`.
  - `s`=1: load `rx_data` from the shift register, pulse `rx_valid` (plus `parity_err` on mismatch; the data is still delivered), then go to IDLE.
  - `s`=0: pulse `frame_err`, leave `rx_data` unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until `s`==1, then go to IDLE. This rule applies to a break condition or a stuck-low line.
- Counters are wide enough for `CLKS_PER_BIT`-1 and N; counter wrap never occurs.

## Timing
- Number clock edges from E0, the first rising edge at which `serial_rx` is low.
  - E2: START is entered.
  - E(2+`HALF`): start bit sampled.
  - E(2+`HALF`+(i+1)·`CLKS_PER_BIT`): data bit i sampled.
  - E(2+`HALF`+(N+1)·`CLKS_PER_BIT`): stop bit sampled, and `rx_valid`/`frame_err` registered high for the following cycle.
  - With parity, add `CLKS_PER_BIT` to the stop-bit edge.
- Default parameters: `rx_valid` high after E154.
- Back-to-back frames: the next start edge may arrive one bit period after the stop bit begins. STOP→IDLE happens at mid-stop, so no frame is missed.
- All outputs are registered; there is no combinational path from `serial_rx`.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - frame is start + N data + even parity + stop;
  - PARITY state present;
  - `parity_err` pulses on mismatch.
- Not defined:
  - frame is start + N data + stop;
  - no PARITY state;
  - `parity_err` tied 0;
  - port list unchanged.

## Structure
- Shared package `uart_pkg` holds:
  - state enum typedef `uart_rx_state_t` (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE);
  - default constants `UART_N`=8 and `UART_CLKS_PER_BIT`=16, shared with the transmitter.
- Sub-module `uart_sync`: 2-flop synchronizer with parameterizable reset value (here 1).

## Test plan
- Frame 0x55, default parameters → `rx_data`=0x55, `rx_valid` high for exactly one cycle after E154, `frame_err`=0.
- `serial_rx` low for 3 cycles, then high → no pulses, `busy` returns to 0 by E(2+`HALF`+1).
- Frame 0xA5 with stop bit driven 0, line held low 40 cycles, then frame 0x3C:
  - `frame_err` pulse once, `rx_data` stays 0x00;
  - no start detected while low;
  - 0x3C then received correctly.
- Frames 0xA5 and 0x3C back-to-back with a single stop bit → two `rx_valid` pulses, 160 cycles apart, with correct data.
- `rst` asserted mid-DATA of frame 0xFF → next cycle all outputs 0 and state IDLE; the following clean frame 0x81 is received.
- With `UART_RX_PARITY_EN`, frame 0x07 with parity bit 0 → `rx_valid` and `parity_err` pulse together, `rx_data`=0x07. With correct parity 1 → `parity_err`=0.
